// File: rtl/fetch_decode_skid_reg.sv
// Fetch/decode pipeline register: two-entry queue (head + skid) with per-thread/global
// flush and a saturating count of flushed instructions. in_ready comes straight from a flop.
module fetch_decode_skid_reg #(
    parameter int unsigned INSTR_WIDTH       = 32,
    parameter int unsigned PC_WIDTH          = 32,
    parameter int unsigned THREAD_INDEX_BITS = 3,
    parameter int unsigned CNT_WIDTH         = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [INSTR_WIDTH-1:0]            in_instruction,
    input  logic [PC_WIDTH-1:0]               in_pc,
    input  logic [THREAD_INDEX_BITS-1:0]      in_thread_index,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [INSTR_WIDTH-1:0]            out_instruction,
    output logic [PC_WIDTH-1:0]               out_pc,
    output logic [THREAD_INDEX_BITS-1:0]      out_thread_index,
    input  logic                              flush_all,
    input  logic [(2**THREAD_INDEX_BITS)-1:0] flush_mask,
    output logic [1:0]                        occupancy,
    output logic [CNT_WIDTH-1:0]              killed_count
);

    typedef struct packed {
        logic [INSTR_WIDTH-1:0]       instr;
        logic [PC_WIDTH-1:0]          pc;
        logic [THREAD_INDEX_BITS-1:0] thr;
    } entry_t;

    localparam logic [CNT_WIDTH+1:0] CNT_MAX = {2'b00, {CNT_WIDTH{1'b1}}};

    entry_t                 h_q, h_d, s_q, s_d, in_e;
    logic                   h_vld_q, h_vld_d, s_vld_q, s_vld_d;
    logic [CNT_WIDTH-1:0]   killed_q, killed_d;
    logic                   accept, pop, h_hit, s_hit, in_hit;
    logic                   h_live, s_live, in_live;
    logic [1:0]             kills;
    logic [CNT_WIDTH+1:0]   cnt_sum;

    assign in_e   = '{instr: in_instruction, pc: in_pc, thr: in_thread_index};
    assign h_hit  = flush_all | flush_mask[h_q.thr];
    assign s_hit  = flush_all | flush_mask[s_q.thr];
    assign in_hit = flush_all | flush_mask[in_thread_index];

    always_comb begin
        pop     = h_vld_q & out_ready;
        accept  = in_valid & ~s_vld_q;
        h_live  = h_vld_q & ~pop & ~h_hit;
        s_live  = s_vld_q & ~s_hit;
        in_live = accept & ~in_hit;
        kills   = {1'b0, h_vld_q & ~pop & h_hit} + {1'b0, s_vld_q & s_hit}
                + {1'b0, accept & in_hit};

        h_d     = h_q;
        s_d     = s_q;
        h_vld_d = 1'b0;
        s_vld_d = 1'b0;
        // An accept implies S was empty, so a surviving S and a new beat never compete
        if (h_live) begin
            h_vld_d = 1'b1;
            if (s_live) begin
                s_vld_d = 1'b1;
            end else if (in_live) begin
                s_vld_d = 1'b1;
                s_d     = in_e;
            end
        end else if (s_live) begin
            h_vld_d = 1'b1;
            h_d     = s_q;
        end else if (in_live) begin
            h_vld_d = 1'b1;
            h_d     = in_e;
        end

        cnt_sum  = {2'b00, killed_q} + {{CNT_WIDTH{1'b0}}, kills};
        killed_d = (cnt_sum > CNT_MAX) ? '1 : cnt_sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_q      <= '0;
            s_q      <= '0;
            h_vld_q  <= 1'b0;
            s_vld_q  <= 1'b0;
            killed_q <= '0;
        end else begin
            h_q      <= h_d;
            s_q      <= s_d;
            h_vld_q  <= h_vld_d;
            s_vld_q  <= s_vld_d;
            killed_q <= killed_d;
        end
    end

    assign in_ready         = ~s_vld_q;
    assign out_valid        = h_vld_q;
    assign out_instruction  = h_q.instr;
    assign out_pc           = h_q.pc;
    assign out_thread_index = h_q.thr;
    assign occupancy        = {1'b0, h_vld_q} + {1'b0, s_vld_q};
    assign killed_count     = killed_q;

endmodule

// File: tb/tb_fetch_decode_skid_reg.sv
// Randomised and directed bench for fetch_decode_skid_reg against a queue-based model.
module tb_fetch_decode_skid_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction;
    logic [31:0] in_pc;
    logic [2:0]  in_thread_index;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [2:0]  out_thread_index;
    logic        flush_all;
    logic [7:0]  flush_mask;
    logic [1:0]  occupancy;
    logic [7:0]  killed_count;

    logic        sat_in_ready, sat_out_valid;
    logic [31:0] sat_out_instruction, sat_out_pc;
    logic [2:0]  sat_out_thread_index;
    logic [1:0]  sat_occupancy;
    logic [1:0]  sat_killed_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  thr;
    } beat_t;

    beat_t mq[$];
    int    mkill = 0;

    always #5 clk = ~clk;

    fetch_decode_skid_reg #(
        .INSTR_WIDTH(32), .PC_WIDTH(32), .THREAD_INDEX_BITS(3), .CNT_WIDTH(8)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction), .in_pc(in_pc), .in_thread_index(in_thread_index),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_pc(out_pc), .out_thread_index(out_thread_index),
        .flush_all(flush_all), .flush_mask(flush_mask),
        .occupancy(occupancy), .killed_count(killed_count)
    );

    fetch_decode_skid_reg #(
        .INSTR_WIDTH(32), .PC_WIDTH(32), .THREAD_INDEX_BITS(3), .CNT_WIDTH(2)
    ) dut_sat (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_instruction(in_instruction), .in_pc(in_pc), .in_thread_index(in_thread_index),
        .out_valid(sat_out_valid), .out_ready(out_ready),
        .out_instruction(sat_out_instruction), .out_pc(sat_out_pc),
        .out_thread_index(sat_out_thread_index),
        .flush_all(flush_all), .flush_mask(flush_mask),
        .occupancy(sat_occupancy), .killed_count(sat_killed_count)
    );

    function automatic int satv(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    function automatic bit is_hit(input logic [2:0] t);
        return flush_all || flush_mask[t];
    endfunction

    // Reference: queue of at most two beats; pop, then drop hit items, then append.
    task automatic model_edge();
        beat_t keep[$];
        beat_t nb;
        bit    acc;
        acc = in_valid && (mq.size() < 2);
        if (out_ready && mq.size() > 0) mq.delete(0);
        foreach (mq[i]) begin
            if (is_hit(mq[i].thr)) mkill++;
            else keep.push_back(mq[i]);
        end
        mq = keep;
        if (acc) begin
            if (is_hit(in_thread_index)) mkill++;
            else begin
                nb.instr = in_instruction;
                nb.pc    = in_pc;
                nb.thr   = in_thread_index;
                mq.push_back(nb);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [2:0] thr, input bit ordy, input bit fa,
                         input logic [7:0] fm);
        in_valid        = v;
        in_instruction  = ins;
        in_pc           = pc;
        in_thread_index = thr;
        out_ready       = ordy;
        flush_all       = fa;
        flush_mask      = fm;
    endtask

    task automatic idle(input bit ordy);
        drive(1'b0, '0, '0, '0, ordy, 1'b0, '0);
    endtask

    task automatic drain();
        idle(1'b1);
        repeat (3) cyc();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle(1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || killed_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_low: out_valid=%b in_ready=%b occ=%0d killed=%0d required 0 1 0 0",
                     out_valid, in_ready, occupancy, killed_count);
        end
        reset = 1'b1;
        mq.delete();
        mkill = 0;
        cyc();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || killed_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_release: out_valid=%b in_ready=%b occ=%0d killed=%0d required 0 1 0 0",
                     out_valid, in_ready, occupancy, killed_count);
        end
    endtask

    task automatic test_streaming();
        int pops = 0;
        drain();
        for (int i = 0; i < 17; i++) begin
            if (i < 16) drive(1'b1, 32'h100 + 32'(i), $urandom, 3'($urandom_range(0, 7)), 1'b1, 1'b0, '0);
            else idle(1'b1);
            if (out_valid) pops++;
            cyc();
            if (i < 16) begin
                checks++;
                if (out_valid !== 1'b1 || out_instruction !== 32'h100 + 32'(i) || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stream[%0d]: valid=%b instr=%h in_ready=%b required 1 %h 1",
                             i, out_valid, out_instruction, in_ready, 32'h100 + 32'(i));
                end
            end
        end
        checks++;
        if (pops != 16 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL stream_pops: pops=%0d occ=%0d required 16 0", pops, occupancy);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_head [3] = '{32'hA, 32'hB, 32'hC};
        drain();
        drive(1'b1, 32'hA, 32'h10, 3'd0, 1'b0, 1'b0, '0); cyc();
        drive(1'b1, 32'hB, 32'h14, 3'd0, 1'b0, 1'b0, '0); cyc();
        checks++;
        if (out_instruction !== 32'hA || occupancy !== 2'd2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: head=%h occ=%0d in_ready=%b required a 2 0",
                     out_instruction, occupancy, in_ready);
        end
        drive(1'b1, 32'hC, 32'h18, 3'd0, 1'b0, 1'b0, '0); cyc();
        checks++;
        if (out_instruction !== 32'hA || occupancy !== 2'd2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: head=%h occ=%0d in_ready=%b required a 2 0",
                     out_instruction, occupancy, in_ready);
        end
        // Release: A pops (C still refused), B pops while C accepted, C pops.
        drive(1'b1, 32'hC, 32'h18, 3'd0, 1'b1, 1'b0, '0); cyc();
        checks++;
        if (out_instruction !== exp_head[1] || occupancy !== 2'd1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_rel1: head=%h occ=%0d in_ready=%b required b 1 1",
                     out_instruction, occupancy, in_ready);
        end
        cyc();
        checks++;
        if (out_instruction !== exp_head[2] || occupancy !== 2'd1) begin
            errors++;
            $display("FAIL bp_rel2: head=%h occ=%0d required c 1", out_instruction, occupancy);
        end
        idle(1'b1); cyc();
        checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: occ=%0d valid=%b required 0 0", occupancy, out_valid);
        end
    endtask

    task automatic test_thread_flush();
        int k0;
        drain();
        drive(1'b1, 32'h2222, 32'h20, 3'd2, 1'b0, 1'b0, '0); cyc();
        drive(1'b1, 32'h5555, 32'h50, 3'd5, 1'b0, 1'b0, '0); cyc();
        k0 = mkill;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 8'h04); cyc();
        idle(1'b0);
        checks++;
        if (out_thread_index !== 3'd5 || out_instruction !== 32'h5555 || occupancy !== 2'd1 ||
            in_ready !== 1'b1 || killed_count !== 8'(satv(k0 + 1, 255))) begin
            errors++;
            $display("FAIL thread_flush: thr=%0d instr=%h occ=%0d in_ready=%b killed=%0d required 5 5555 1 1 %0d",
                     out_thread_index, out_instruction, occupancy, in_ready, killed_count, satv(k0 + 1, 255));
        end
    endtask

    task automatic test_flush_pop_accept();
        int k0;
        drain();
        drive(1'b1, 32'h1111, 32'h30, 3'd1, 1'b0, 1'b0, '0); cyc();
        k0 = mkill;
        drive(1'b1, 32'h3333, 32'h34, 3'd3, 1'b1, 1'b1, '0); cyc();
        idle(1'b0);
        checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || killed_count !== 8'(satv(k0 + 1, 255))) begin
            errors++;
            $display("FAIL fpa_h_only: occ=%0d valid=%b killed=%0d required 0 0 %0d",
                     occupancy, out_valid, killed_count, satv(k0 + 1, 255));
        end
        drive(1'b1, 32'h1112, 32'h40, 3'd1, 1'b0, 1'b0, '0); cyc();
        drive(1'b1, 32'h6666, 32'h44, 3'd6, 1'b0, 1'b0, '0); cyc();
        k0 = mkill;
        drive(1'b1, 32'h3334, 32'h48, 3'd3, 1'b1, 1'b1, '0); cyc();
        idle(1'b0);
        checks++;
        if (occupancy !== 2'd0 || in_ready !== 1'b1 || killed_count !== 8'(satv(k0 + 1, 255))) begin
            errors++;
            $display("FAIL fpa_h_and_s: occ=%0d in_ready=%b killed=%0d required 0 1 %0d",
                     occupancy, in_ready, killed_count, satv(k0 + 1, 255));
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom, 3'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                  ($urandom_range(0, 7) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
            cyc();
            checks++;
            if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) ||
                occupancy !== 2'(mq.size()) || killed_count !== 8'(satv(mkill, 255))) begin
                errors++;
                $display("FAIL rand_flags[%0d]: valid=%b in_ready=%b occ=%0d killed=%0d required size=%0d killed=%0d",
                         n, out_valid, in_ready, occupancy, killed_count, mq.size(), satv(mkill, 255));
            end
            if (mq.size() > 0) begin
                checks++;
                if (out_instruction !== mq[0].instr || out_pc !== mq[0].pc ||
                    out_thread_index !== mq[0].thr) begin
                    errors++;
                    $display("FAIL rand_head[%0d]: %h/%h/%0d required %h/%h/%0d", n,
                             out_instruction, out_pc, out_thread_index,
                             mq[0].instr, mq[0].pc, mq[0].thr);
                end
            end
        end
        drain();
    endtask

    task automatic test_saturation();
        reset = 1'b0;
        idle(1'b1);
        @(negedge clk);
        reset = 1'b1;
        mq.delete();
        mkill = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'b1, 1'b1, '0);
            cyc();
            checks++;
            if (sat_killed_count !== 2'(satv(i + 1, 3))) begin
                errors++;
                $display("FAIL sat_step[%0d]: killed=%0d required %0d", i, sat_killed_count, satv(i + 1, 3));
            end
        end
        idle(1'b1);
        repeat (3) cyc();
        checks++;
        if (sat_killed_count !== 2'd3 || killed_count !== 8'd5 || sat_occupancy !== 2'd0) begin
            errors++;
            $display("FAIL sat_hold: sat_killed=%0d killed=%0d sat_occ=%0d required 3 5 0",
                     sat_killed_count, killed_count, sat_occupancy);
        end
    endtask

    task automatic test_reset_midstream();
        drain();
        drive(1'b1, 32'h77, 32'h70, 3'd7, 1'b0, 1'b0, '0); cyc();
        drive(1'b1, 32'h88, 32'h80, 3'd0, 1'b0, 1'b0, '0); cyc();
        checks++;
        if (occupancy !== 2'd2) begin
            errors++;
            $display("FAIL mid_prefill: occ=%0d required 2", occupancy);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || killed_count !== 8'd0) begin
            errors++;
            $display("FAIL mid_async: valid=%b in_ready=%b occ=%0d killed=%0d required 0 1 0 0",
                     out_valid, in_ready, occupancy, killed_count);
        end
        mq.delete();
        mkill = 0;
        idle(1'b1);
        @(negedge clk);
        reset = 1'b1;
        cyc();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || killed_count !== 8'd0) begin
            errors++;
            $display("FAIL mid_release: valid=%b in_ready=%b occ=%0d killed=%0d required 0 1 0 0",
                     out_valid, in_ready, occupancy, killed_count);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_thread_flush();
        test_flush_pop_accept();
        test_random();
        test_saturation();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
